dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory (dm) between master 0 (CPU load/store path) and master 1 (debug/DMA loader).
- Grants one access at a time using round-robin priority, drives the dm write/read strobes for exactly one cycle, and returns an acknowledge plus registered read data to the owner.
- Sits between the datapath memory stage and dm.

Parameters:
- ADDR_W, 8, word address width; matches dm depth of 256 words.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- m0_req  input  1  master 0 request; held with payload until m0_ack sampled high.
- m0_we  input  1  master 0 access type; 1 = write, 0 = read.
- m0_addr  input  ADDR_W  master 0 word address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_ack  output  1  one-cycle pulse: master 0 access complete.
- m0_rdata  output  DATA_W  master 0 read data; valid when m0_ack=1 on a read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0_* ports, for master 1.
- dm_addr  output  ADDR_W  to dm addr.
- dm_data_in  output  DATA_W  to dm data_in.
- dm_write_enable  output  1  to dm write_enable.
- dm_read_enable  output  1  to dm read_enable.
- dm_data_out  input  DATA_W  from dm data_out.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (rst_n low, immediate):
  - State = IDLE, owner = 0, rr_ptr = 0 (master 0 preferred).
  - All acks 0; both rdata = 0.
  - dm_addr, dm_data_in = 0; dm_write_enable, dm_read_enable = 0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE, fixed 3 cycles per access.
- IDLE:
  - If any req is high, select the winner, latch owner/we/addr/wdata into registers and go to ACCESS.
  - Otherwise stay in IDLE.
  - Both dm enables are 0.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the master indicated by rr_ptr wins.
  - rr_ptr is set to the non-winner on every grant, so under continuous contention the masters alternate strictly.
- ACCESS (exactly 1 cycle):
  - dm_addr and dm_data_in are driven from the latched registers.
  - dm_write_enable = latched we; dm_read_enable = !latched we.
  - Writes commit at the closing posedge.
  - On reads, dm_data_out is captured into the owner's rdata register at the closing posedge.
  - Go to DONE.
- DONE (1 cycle):
  - Owner's ack = 1. The owner's rdata holds the read value; on writes it is unchanged.
  - dm enables = 0; dm_addr and dm_data_in hold their last values.
  - Go to IDLE unconditionally.
- Output stability:
  - Non-owner ack stays 0.
  - rdata registers hold their value until that master's next read completes.
- Request handshake:
  - The payload is sampled only in IDLE. Changes to req or payload after the grant are ignored until DONE completes.
  - A requester that keeps req high past ack is treated as issuing a new request, which is arbitrated in the following IDLE.
- Latency and throughput:
  - Uncontended: req high in cycle N gives ack in cycle N+2 (sampled at posedge N+3).
  - Peak throughput is 1 access per 3 cycles.
  - Under contention, worst-case wait is one foreign access (3 cycles) plus own access.
- Reset mid-operation:
  - Abandons the transaction with no ack.
  - A write is committed only if rst_n was high at the closing posedge of ACCESS.
- Address is exactly ADDR_W bits, with no translation or wrap logic; dm indexes modulo 2^ADDR_W.
- No combinational path from any req to any dm_* output or ack.

Decomposition:
- Shared package/header dm_arb_defs:
  - State encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2.
  - Master index constants M0=1'b0, M1=1'b1.
- One natural sub-module: rr_arb2, a combinational two-way round-robin pick (inputs req[1:0] and rr_ptr; outputs grant index and valid).
- The FSM, latches and rdata registers stay in dm_arbiter.

Test Plan:
- Reset check: assert rst_n=0 mid-ACCESS -> all outputs 0 immediately; no ack; state IDLE on release.
- Single write then read: m0 write 0xDEADBEEF @0x10, then m0 read @0x10 -> each m0_ack at req+2 cycles; m0_rdata = 0xDEADBEEF; dm_write_enable high exactly 1 cycle.
- Simultaneous requests after reset: m0 reads @0x01, m1 reads @0x02 (preloaded 0x11, 0x22) -> m0 served first (ack cycle 2), m1 next (ack cycle 5); m0_rdata = 0x11, m1_rdata = 0x22; m1_ack never coincides with m0_ack.
- Continuous contention: both hold req for 6 accesses -> grant order m0, m1, m0, m1, m0, m1; one ack every 3 cycles.
- Back-to-back same master: m1 holds req through ack with a new address -> second access granted in the next IDLE; m0_rdata unchanged throughout.
- Payload change after grant: m0 changes addr 0x05 -> 0x06 during ACCESS -> dm_addr stays 0x05; write lands at 0x05 only.

Source files
------------

// File: rtl/dm_arb_defs_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, master ids, widths.
package dm_arb_defs;

    localparam int unsigned DM_ADDR_W = 8;
    localparam int unsigned DM_DATA_W = 32;

    // Access sequencing: every grant takes exactly IDLE -> ACCESS -> DONE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Master index values, as used for owner, grant and rr_ptr.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick (combinational).
//   req[1:0] : request vector, bit i = master i
//   rr_ptr   : master preferred when both request
//   grant_c  : index of the winning master
//   valid_c  : at least one request present
module rr_arb2
    import dm_arb_defs::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       grant_c,
    output logic       valid_c
);

    always_comb begin
        valid_c = |req;
        grant_c = M0;
        unique case (req)
            2'b01:   grant_c = M0;
            2'b10:   grant_c = M1;
            2'b11:   grant_c = rr_ptr;
            default: grant_c = M0;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between master 0 (CPU) and master 1 (debug/DMA).
// One access per 3 cycles: IDLE (arbitrate + latch) -> ACCESS (strobe dm) -> DONE (ack).
//   clk, rst_n          : clock, async active-low reset
//   mN_req/we/addr/wdata: master N request and payload, held until mN_ack
//   mN_ack              : one-cycle completion pulse
//   mN_rdata            : read data, held until master N's next read completes
//   dm_*                : memory side; strobes high only during ACCESS
module dm_arbiter
    import dm_arb_defs::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_data_in,
    output logic              dm_write_enable,
    output logic              dm_read_enable,
    input  logic [DATA_W-1:0] dm_data_out
);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                we_en_d, re_en_d;
    logic                ack0_d, ack1_d;
    logic [DATA_W-1:0]   rdata0_d, rdata1_d;

    logic                grant_c;
    logic                valid_c;

    rr_arb2 u_rr_arb2 (
        .req     ({m1_req, m0_req}),
        .rr_ptr  (rr_ptr_q),
        .grant_c (grant_c),
        .valid_c (valid_c)
    );

    // State and all outputs are registered; the dm_addr/dm_data_in registers double
    // as the latched payload, so they keep their last value outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= M0;
            rr_ptr_q        <= M0;
            dm_addr         <= '0;
            dm_data_in      <= '0;
            dm_write_enable <= 1'b0;
            dm_read_enable  <= 1'b0;
            m0_ack          <= 1'b0;
            m1_ack          <= 1'b0;
            m0_rdata        <= '0;
            m1_rdata        <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            dm_addr         <= addr_d;
            dm_data_in      <= wdata_d;
            dm_write_enable <= we_en_d;
            dm_read_enable  <= re_en_d;
            m0_ack          <= ack0_d;
            m1_ack          <= ack1_d;
            m0_rdata        <= rdata0_d;
            m1_rdata        <= rdata1_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = dm_addr;
        wdata_d  = dm_data_in;
        we_en_d  = 1'b0;
        re_en_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = m0_rdata;
        rdata1_d = m1_rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_c) begin
                    owner_d  = grant_c;
                    rr_ptr_d = ~grant_c;
                    if (grant_c == M1) begin
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        we_en_d = m1_we;
                        re_en_d = ~m1_we;
                    end else begin
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        we_en_d = m0_we;
                        re_en_d = ~m0_we;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ack and read capture take effect together, so rdata is valid with ack.
                if (owner_q == M1) begin
                    ack1_d = 1'b1;
                    if (dm_read_enable) rdata1_d = dm_data_out;
                end else begin
                    ack0_d = 1'b1;
                    if (dm_read_enable) rdata0_d = dm_data_out;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 256x32 data memory.
module tb_dm_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [7:0]  dm_addr;
    logic [31:0] dm_data_in;
    logic        dm_write_enable, dm_read_enable;
    logic [31:0] dm_data_out;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    dm_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_data_in(dm_data_in),
        .dm_write_enable(dm_write_enable), .dm_read_enable(dm_read_enable),
        .dm_data_out(dm_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: synchronous write, asynchronous read.
    always @(posedge clk) if (dm_write_enable) mem[dm_addr] <= dm_data_in;
    assign dm_data_out = mem[dm_addr];

    typedef struct packed {
        logic        m0_req;
        logic        m0_we;
        logic [7:0]  m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic [7:0]  m1_addr;
        logic        e_ack0;
        logic        e_ack1;
        logic        e_we;
        logic        e_re;
        logic [7:0]  e_addr;
        logic [31:0] e_din;
        logic [31:0] e_r0;
        logic [31:0] e_r1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r0q, w0, input logic [7:0] a0, input logic [31:0] d0,
                                input logic r1q, input logic [7:0] a1,
                                input logic k0, k1, we, re, input logic [7:0] ea,
                                input logic [31:0] ed, er0, er1);
        vec_t v;
        v.m0_req = r0q; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
        v.m1_req = r1q; v.m1_addr = a1;
        v.e_ack0 = k0; v.e_ack1 = k1; v.e_we = we; v.e_re = re;
        v.e_addr = ea; v.e_din = ed; v.e_r0 = er0; v.e_r1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    // Single access through one master; checks the 2-cycle request-to-ack latency.
    task automatic xfer(input logic m, input logic we, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
        int lat;
        lat = 0;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
        do begin
            tick();
            lat++;
        end while (!(m ? m1_ack : m0_ack) && lat < 10);
        chk($sformatf("xfer_latency m%0d", m), 32'(lat), 32'd2);
        rd = m ? m1_rdata : m0_rdata;
        idle_inputs();
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] old6, old20;
        int ack_cnt, last_ack, cyc;
        logic exp_m;

        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        // Reset values
        chk("rst m0_ack", 32'(m0_ack), 0);
        chk("rst m1_ack", 32'(m1_ack), 0);
        chk("rst m0_rdata", m0_rdata, 0);
        chk("rst m1_rdata", m1_rdata, 0);
        chk("rst dm_addr", 32'(dm_addr), 0);
        chk("rst dm_data_in", dm_data_in, 0);
        chk("rst dm_we", 32'(dm_write_enable), 0);
        chk("rst dm_re", 32'(dm_read_enable), 0);
        rst_n = 1;
        tick();

        // Preload memory through the arbiter, then reset to restore rr_ptr/rdata.
        xfer(1'b1, 1'b1, 8'h01, 32'h11, rd);
        xfer(1'b1, 1'b1, 8'h02, 32'h22, rd);
        old6 = mem[6];
        pulse_reset();

        // Cycle-by-cycle vectors: inputs applied, then outputs checked after the next edge.
        vecs.push_back(mk(1,0,8'h01,0, 1,8'h02, 0,0,0,1,8'h01,0, 0,0));
        vecs.push_back(mk(1,0,8'h01,0, 1,8'h02, 1,0,0,0,8'h01,0, 32'h11,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,8'h02, 0,0,0,0,8'h01,0, 32'h11,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,8'h02, 0,0,0,1,8'h02,0, 32'h11,0));
        vecs.push_back(mk(0,0,8'h00,0, 1,8'h02, 0,1,0,0,8'h02,0, 32'h11,32'h22));
        vecs.push_back(mk(0,0,8'h00,0, 0,8'h00, 0,0,0,0,8'h02,0, 32'h11,32'h22));
        vecs.push_back(mk(1,1,8'h10,32'hDEADBEEF, 0,0, 0,0,1,0,8'h10,32'hDEADBEEF, 32'h11,32'h22));
        vecs.push_back(mk(1,1,8'h10,32'hDEADBEEF, 0,0, 1,0,0,0,8'h10,32'hDEADBEEF, 32'h11,32'h22));
        vecs.push_back(mk(0,0,8'h00,0, 0,0, 0,0,0,0,8'h10,32'hDEADBEEF, 32'h11,32'h22));
        vecs.push_back(mk(1,0,8'h10,0, 0,0, 0,0,0,1,8'h10,0, 32'h11,32'h22));
        vecs.push_back(mk(1,0,8'h10,0, 0,0, 1,0,0,0,8'h10,0, 32'hDEADBEEF,32'h22));
        vecs.push_back(mk(0,0,8'h00,0, 0,0, 0,0,0,0,8'h10,0, 32'hDEADBEEF,32'h22));
        vecs.push_back(mk(1,1,8'h05,32'hA5, 0,0, 0,0,1,0,8'h05,32'hA5, 32'hDEADBEEF,32'h22));
        vecs.push_back(mk(1,1,8'h06,32'h66, 0,0, 1,0,0,0,8'h05,32'hA5, 32'hDEADBEEF,32'h22));
        vecs.push_back(mk(0,0,8'h00,0, 0,0, 0,0,0,0,8'h05,32'hA5, 32'hDEADBEEF,32'h22));

        for (int i = 0; i < vecs.size(); i++) begin
            m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
            m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
            m1_req = vecs[i].m1_req; m1_we = 1'b0; m1_addr = vecs[i].m1_addr; m1_wdata = 0;
            tick();
            chk($sformatf("v%0d m0_ack", i), 32'(m0_ack), 32'(vecs[i].e_ack0));
            chk($sformatf("v%0d m1_ack", i), 32'(m1_ack), 32'(vecs[i].e_ack1));
            chk($sformatf("v%0d dm_we", i), 32'(dm_write_enable), 32'(vecs[i].e_we));
            chk($sformatf("v%0d dm_re", i), 32'(dm_read_enable), 32'(vecs[i].e_re));
            chk($sformatf("v%0d dm_addr", i), 32'(dm_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d dm_data_in", i), dm_data_in, vecs[i].e_din);
            chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].e_r0);
            chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].e_r1);
        end
        chk("mem[0x10]", mem[8'h10], 32'hDEADBEEF);
        chk("mem[0x05]", mem[8'h05], 32'hA5);
        chk("mem[0x06] untouched", mem[8'h06], old6);

        // Continuous contention from reset: strict alternation, one ack per 3 cycles.
        idle_inputs();
        pulse_reset();
        m0_req = 1; m0_addr = 8'h01;
        m1_req = 1; m1_addr = 8'h02;
        ack_cnt = 0; last_ack = 0; exp_m = 1'b0;
        for (cyc = 1; cyc <= 30 && ack_cnt < 6; cyc++) begin
            tick();
            if (m0_ack && m1_ack) chk("contention both acks", 32'(m1_ack), 0);
            if (m0_ack || m1_ack) begin
                chk($sformatf("contention order %0d", ack_cnt), 32'(m1_ack), 32'(exp_m));
                chk($sformatf("contention spacing %0d", ack_cnt), 32'(cyc - last_ack),
                    (ack_cnt == 0) ? 32'd2 : 32'd3);
                chk($sformatf("contention rdata %0d", ack_cnt),
                    m1_ack ? m1_rdata : m0_rdata, m1_ack ? 32'h22 : 32'h11);
                last_ack = cyc;
                ack_cnt++;
                exp_m = ~exp_m;
            end
        end
        chk("contention ack count", 32'(ack_cnt), 32'd6);

        // Drain whatever is in flight.
        idle_inputs();
        repeat (4) tick();

        // Back-to-back m1: keeps req high through ack with a new address.
        m1_req = 1; m1_addr = 8'h10;
        cyc = 0;
        do begin tick(); cyc++; end while (!m1_ack && cyc < 10);
        chk("b2b first ack", 32'(m1_ack), 1);
        chk("b2b first rdata", m1_rdata, 32'hDEADBEEF);
        m1_addr = 8'h02;
        tick();
        chk("b2b idle ack", 32'(m1_ack), 0);
        chk("b2b idle re", 32'(dm_read_enable), 0);
        tick();
        chk("b2b access addr", 32'(dm_addr), 32'h02);
        chk("b2b access re", 32'(dm_read_enable), 1);
        m1_req = 0;
        tick();
        chk("b2b second ack", 32'(m1_ack), 1);
        chk("b2b second rdata", m1_rdata, 32'h22);
        chk("b2b m0_rdata held", m0_rdata, 32'h11);
        chk("b2b m0_ack quiet", 32'(m0_ack), 0);
        tick();

        // Reset asserted in the middle of a write's ACCESS cycle.
        old20 = mem[8'h20];
        m0_req = 1; m0_we = 1; m0_addr = 8'h20; m0_wdata = 32'h1234_5678;
        tick();
        chk("rstmid access we", 32'(dm_write_enable), 1);
        #2;
        rst_n = 0;
        #1;
        chk("rstmid dm_we", 32'(dm_write_enable), 0);
        chk("rstmid dm_re", 32'(dm_read_enable), 0);
        chk("rstmid dm_addr", 32'(dm_addr), 0);
        chk("rstmid dm_data_in", dm_data_in, 0);
        chk("rstmid m0_ack", 32'(m0_ack), 0);
        chk("rstmid m0_rdata", m0_rdata, 0);
        chk("rstmid m1_rdata", m1_rdata, 0);
        idle_inputs();
        tick();
        chk("rstmid write dropped", mem[8'h20], old20);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstmid no ack %0d", i), 32'({m1_ack, m0_ack}), 0);
        end
        xfer(1'b0, 1'b0, 8'h20, 32'h0, rd);
        chk("rstmid reread", rd, old20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
